pipeline_share_arbiter: RTL and testbench
=========================================

Name: pipeline_share_arbiter

Overview:
- Shares one pipeline_propagation_core instance (fixed PSTAGE latency, ce-gated) among NREQ requesters.
- Round-robin arbitration selects at most one request per cycle and drives the pipeline's ce and data_in.
- A PSTAGE-deep tag shadow pipeline returns each result to the requester that issued it.
- Sits between front-end trigger sources and the shared pipeline core.

Parameters:
DATA_WIDTH, 32, width of request/response data and of the pipeline datapath
PSTAGE, 3, latency of the attached pipeline core in ce-enabled cycles (>=1)
NREQ, 4, number of requesters (2..8)

Ports:
clk  in  1  system clock
arst  in  1  reset, synchronous to clk, active-high (despite the name, no asynchronous path)
req_valid  in  NREQ  per-requester request valid
req_data  in  NREQ*DATA_WIDTH  flattened request data, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NREQ  one-hot grant; transfer when req_valid[i]&req_ready[i]
hold  in  1  global stall; freezes pipeline and tag shadow
drain_req  in  1  level; stop accepting, empty pipeline
pipe_ce  out  1  to core ce
pipe_data_in  out  DATA_WIDTH  to core data_in
pipe_data_o  in  DATA_WIDTH  from core data_o
rsp_valid  out  NREQ  one-hot response strobe
rsp_data  out  DATA_WIDTH  response data (=pipe_data_o)
busy  out  1  any tag valid in shadow pipeline
drained  out  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Reset (arst=1 at a clk edge): rr pointer=0, all tag valids=0, state=IDLE.
  - During and after reset: req_ready=0, rsp_valid=0, busy=0, drained=0.
  - arst mid-operation discards all in-flight tags; results still in the core are never reported.
- pipe_ce = ~hold & ~arst. pipe_data_in = req_data of the granted requester, else 0 (combinational).
- Grant (combinational): when state!=DRAIN and pipe_ce=1, req_ready = first req_valid bit at or after rr pointer, cyclically; otherwise 0.
  - req_ready is never asserted without req_valid.
- rr pointer: on each accepted transfer, becomes (granted index+1) mod NREQ. Unchanged when there is no transfer.
- Tag shadow: PSTAGE registers of {vld, idx[clog2(NREQ)-1:0]}, shifted only when pipe_ce=1.
  - Stage0 input is {transfer, granted idx}.
- rsp_valid[idx_last] = vld_last & pipe_ce: exactly one strobe per accepted request, even across hold.
  - rsp_data = pipe_data_o.
- Latency: request accepted at edge N with no hold -> rsp_valid in cycle N+PSTAGE (PSTAGE cycles after the accept cycle). Each hold cycle adds one.
- busy = OR of shadow vld bits.
- FSM:
  - IDLE: busy=0. Any transfer -> RUN. drain_req -> drained pulse, stay IDLE.
  - RUN: drain_req -> DRAIN. busy=0 and no transfer this cycle -> IDLE.
  - DRAIN: no grants. When busy=0 (after the final rsp shifts out) -> IDLE with drained=1 for one cycle. drain_req still high in IDLE holds grants off.
- Simultaneous events:
  - hold overrides grant.
  - drain_req and req_valid in the same cycle while in RUN: the request is still granted in that cycle; DRAIN takes effect next cycle.
  - arst overrides everything.
- Full throughput: one accept per cycle sustained while any req_valid is high and hold=0.

Optional Feature:
- Macro PIPE_ARB_STATS_EN.
- Defined:
  - Adds input stat_sel [clog2(NREQ)-1:0], input stat_clr, output stat_cnt [15:0].
  - Per-requester 16-bit grant counters, saturating at 16'hFFFF.
  - Cleared by arst or stat_clr (stat_clr wins over an increment in the same cycle).
  - stat_cnt = counter[stat_sel], registered, 1-cycle latency.
- Undefined: ports absent, no counters, behaviour otherwise identical.

Test Plan:
1. NREQ=4, PSTAGE=3; only req 2 valid, data 0x10..0x19, 10 cycles -> req_ready[2] every cycle; rsp_valid[2] with 0x10..0x19, first strobe 3 cycles after first accept.
2. All four valid continuously, 8 cycles -> grant order 0,1,2,3,0,1,2,3; each rsp_valid one-hot and matched to its issuer's data.
3. Single accept, then hold high 5 cycles mid-flight -> pipe_ce=0, no req_ready, rsp_valid delayed by exactly 5 cycles and asserted exactly once.
4. Stream 6 requests, drain_req raised after the 3rd accept -> no further grants; rsp for all 3 accepted requests; drained pulses one cycle after the last rsp; state IDLE, busy=0.
5. arst asserted 1 cycle with 2 requests in flight -> no rsp_valid for them; busy=0 next cycle; rr pointer restarts at 0.
6. (PIPE_ARB_STATS_EN) 70000 accepts from req 1 -> stat_cnt=16'hFFFF with stat_sel=1; pulse stat_clr -> 0.

Source files
------------

// File: rtl/pipeline_share_arbiter.sv
// pipeline_share_arbiter: round-robin front end sharing one fixed-latency,
// ce-gated pipeline core among NREQ requesters, with a tag shadow pipeline.
//
// Ports:
//   clk, arst        clock; synchronous active-high reset
//   req_valid/data   per-requester request (data flattened, DATA_WIDTH each)
//   req_ready        one-hot grant, only asserted with req_valid
//   hold             global stall of the core and the tag shadow
//   drain_req        stop granting and let in-flight work complete
//   pipe_ce          core clock enable
//   pipe_data_in     data to the core (granted request, else 0)
//   pipe_data_o      data from the core
//   rsp_valid        one-hot response strobe to the issuing requester
//   rsp_data         response data (pipe_data_o)
//   busy             any tag in flight
//   drained          one-cycle pulse when a drain completes
//
// Optional build macro PIPE_ARB_STATS_EN adds per-requester saturating
// grant counters read through stat_sel/stat_cnt and cleared by stat_clr.

module pipeline_share_arbiter #(
    parameter  int DATA_WIDTH = 32,
    parameter  int PSTAGE     = 3,
    parameter  int NREQ       = 4,
    localparam int IW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       hold,
    input  logic                       drain_req,
    output logic                       pipe_ce,
    output logic [DATA_WIDTH-1:0]      pipe_data_in,
    input  logic [DATA_WIDTH-1:0]      pipe_data_o,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       busy,
`ifdef PIPE_ARB_STATS_EN
    input  logic [IW-1:0]              stat_sel,
    input  logic                       stat_clr,
    output logic [15:0]                stat_cnt,
`endif
    output logic                       drained
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [PSTAGE-1:0] r_vld;
    logic [IW-1:0]   r_idx [PSTAGE];
    logic            r_drain_q;

    logic            w_ce;
    logic            w_grant_en;
    logic            w_xfer;
    logic [IW-1:0]   w_gidx;
    logic [IW:0]     w_sum;
    logic            w_busy;
    logic            w_drained;

    // ------------------------------------------------------------
    // Core enable and grant qualification
    // ------------------------------------------------------------
    assign w_ce = ~hold & ~arst;

    // Drain blocks new work; a drain request still high after the
    // drain completed keeps the idle arbiter closed.
    assign w_grant_en = w_ce
                      && (r_state != S_DRAIN)
                      && !((r_state == S_IDLE) && drain_req);

    // ------------------------------------------------------------
    // Round-robin pick: first valid at or after r_ptr, cyclically
    // ------------------------------------------------------------
    always_comb begin
        w_xfer = 1'b0;
        w_gidx = '0;
        w_sum  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            if (!w_xfer && w_grant_en && req_valid[w_sum[IW-1:0]]) begin
                w_xfer = 1'b1;
                w_gidx = w_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        req_ready    = '0;
        pipe_data_in = '0;
        if (w_xfer) begin
            req_ready[w_gidx] = 1'b1;
            pipe_data_in = req_data[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign pipe_ce = w_ce;

    // ------------------------------------------------------------
    // Pointer and tag shadow (moves in lockstep with the core)
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (arst) begin
            r_ptr <= '0;
            r_vld <= '0;
            for (int i = 0; i < PSTAGE; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_ptr <= (w_gidx == IW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
            end
            if (w_ce) begin
                r_vld[0] <= w_xfer;
                r_idx[0] <= w_gidx;
                for (int i = 1; i < PSTAGE; i++) begin
                    r_vld[i] <= r_vld[i-1];
                    r_idx[i] <= r_idx[i-1];
                end
            end
        end
    end

    assign w_busy = |r_vld;
    assign busy   = w_busy & ~arst;

    // The last-stage tag is consumed only on a ce cycle, so a held
    // result is strobed exactly once when the stall lifts.
    always_comb begin
        rsp_valid = '0;
        if (r_vld[PSTAGE-1] && w_ce) begin
            rsp_valid[r_idx[PSTAGE-1]] = 1'b1;
        end
    end

    assign rsp_data = pipe_data_o;

    // ------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (arst) begin
            r_state   <= S_IDLE;
            r_drain_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_drain_q <= drain_req;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drained   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = S_RUN;
                end else if (drain_req && !r_drain_q) begin
                    // Nothing in flight: acknowledge a fresh drain now.
                    w_drained = 1'b1;
                end
            end
            S_RUN: begin
                if (drain_req) begin
                    w_state_nxt = S_DRAIN;
                end else if (!w_busy && !w_xfer) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!w_busy) begin
                    w_state_nxt = S_IDLE;
                    w_drained   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign drained = w_drained & ~arst;

`ifdef PIPE_ARB_STATS_EN
    // ------------------------------------------------------------
    // Grant statistics
    // ------------------------------------------------------------
    logic [15:0] r_cnt [NREQ];
    logic [15:0] r_stat_cnt;

    always_ff @(posedge clk) begin
        if (arst || stat_clr) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_xfer && (r_cnt[w_gidx] != 16'hFFFF)) begin
            r_cnt[w_gidx] <= r_cnt[w_gidx] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_stat_cnt <= '0;
        end else begin
            r_stat_cnt <= r_cnt[stat_sel];
        end
    end

    assign stat_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_pipeline_share_arbiter.sv
// tb_pipeline_share_arbiter: scoreboard bench for pipeline_share_arbiter
// with a behavioural ce-gated delay line standing in for the shared core.

module tb_pipeline_share_arbiter;

    localparam int DW = 32;
    localparam int PS = 3;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              arst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              hold;
    logic              drain_req;
    logic              pipe_ce;
    logic [DW-1:0]     pipe_data_in;
    logic [DW-1:0]     pipe_data_o;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              busy;
    logic              drained;
`ifdef PIPE_ARB_STATS_EN
    logic [1:0]        stat_sel;
    logic              stat_clr;
    logic [15:0]       stat_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_share_arbiter #(
        .DATA_WIDTH (DW),
        .PSTAGE     (PS),
        .NREQ       (NR)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .hold         (hold),
        .drain_req    (drain_req),
        .pipe_ce      (pipe_ce),
        .pipe_data_in (pipe_data_in),
        .pipe_data_o  (pipe_data_o),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy),
`ifdef PIPE_ARB_STATS_EN
        .stat_sel     (stat_sel),
        .stat_clr     (stat_clr),
        .stat_cnt     (stat_cnt),
`endif
        .drained      (drained)
    );

    // Shared core: PS-deep delay line advancing only on pipe_ce.
    logic [DW-1:0] core_q [PS];
    always @(posedge clk) begin
        if (pipe_ce) begin
            core_q[0] <= pipe_data_in;
            for (int i = 1; i < PS; i++) core_q[i] <= core_q[i-1];
        end
    end
    assign pipe_data_o = core_q[PS-1];

    typedef struct packed {
        logic [7:0]    idx;
        logic [DW-1:0] data;
    } sb_t;

    sb_t sbq[$];
    sb_t sb_e;
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  n_acc, n_rsp, first_acc, first_rsp, last_acc, last_rsp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Monitor: accepted requests go into the scoreboard, responses
    // are popped in issue order and matched on requester and data.
    always @(negedge clk) begin
        if (!arst) begin
            check_eq("ready_subset", req_ready & ~req_valid, 0);
            check_eq("ready_onehot", $countones(req_ready) <= 1, 1);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sbq.push_back('{idx: 8'(i), data: req_data[i*DW +: DW]});
                    n_acc++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
            end
            if (rsp_valid != 0) begin
                check_eq("rsp_onehot", $countones(rsp_valid), 1);
                if (sbq.size() == 0) begin
                    check_eq("rsp_unexpected", rsp_valid, 0);
                end else begin
                    sb_e = sbq.pop_front();
                    check_eq("rsp_idx", rsp_valid, 64'(1) << sb_e.idx);
                    check_eq("rsp_data", rsp_data, sb_e.data);
                end
                n_rsp++;
                if (first_rsp < 0) first_rsp = cyc;
                last_rsp = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        n_acc = 0;
        n_rsp = 0;
        first_acc = -1;
        first_rsp = -1;
        last_acc = -1;
        last_rsp = -1;
    endtask

    task automatic setd(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset(input int n);
        arst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check_eq("rst_ready", req_ready, 0);
            check_eq("rst_rsp", rsp_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_drained", drained, 0);
            check_eq("rst_ce", pipe_ce, 0);
            step();
        end
        arst = 1'b0;
        sbq.delete();
    endtask

    int  dcyc;
    bit  seen;

    initial begin
        arst = 1'b1;
        hold = 1'b0;
        drain_req = 1'b0;
        req_valid = '0;
        req_data = '0;
`ifdef PIPE_ARB_STATS_EN
        stat_sel = '0;
        stat_clr = 1'b0;
`endif
        clr_cnt();
        do_reset(2);
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_ready", req_ready, 0);
        check_eq("post_rst_ce", pipe_ce, 1);
        step();

        // 1: single requester streaming
        clr_cnt();
        for (int k = 0; k < 10; k++) begin
            req_valid = 4'b0100;
            setd(2, 32'h10 + k);
            @(negedge clk);
            check_eq("t1_ready", req_ready, 4'b0100);
            check_eq("t1_pdin", pipe_data_in, 32'h10 + k);
            step();
        end
        req_valid = '0;
        repeat (PS + 3) step();
        check_eq("t1_acc", n_acc, 10);
        check_eq("t1_rsp", n_rsp, 10);
        check_eq("t1_lat", first_rsp - first_acc, PS);
        check_eq("t1_sb_empty", sbq.size(), 0);

        // 2: all requesters, round-robin order from pointer 0
        do_reset(1);
        clr_cnt();
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'b1111;
            for (int i = 0; i < NR; i++) setd(i, 32'h100 * (i + 1) + k);
            @(negedge clk);
            check_eq("t2_grant", req_ready, 1 << (k % 4));
            step();
        end
        req_valid = '0;
        repeat (PS + 3) step();
        check_eq("t2_acc", n_acc, 8);
        check_eq("t2_rsp", n_rsp, 8);
        check_eq("t2_sb_empty", sbq.size(), 0);
        check_eq("t2_busy", busy, 0);

        // 3: hold mid-flight
        clr_cnt();
        req_valid = 4'b0001;
        setd(0, 32'hA5A5);
        @(negedge clk);
        check_eq("t3_ready", req_ready, 4'b0001);
        step();
        hold = 1'b1;
        req_valid = 4'b0010;
        setd(1, 32'hBEEF);
        repeat (5) begin
            @(negedge clk);
            check_eq("t3_hold_ready", req_ready, 0);
            check_eq("t3_hold_ce", pipe_ce, 0);
            check_eq("t3_hold_rsp", rsp_valid, 0);
            step();
        end
        hold = 1'b0;
        req_valid = '0;
        repeat (10) step();
        check_eq("t3_rsp", n_rsp, 1);
        check_eq("t3_lat", last_rsp - first_acc, PS + 5);
        check_eq("t3_busy", busy, 0);

        // 4: drain after the third accept
        clr_cnt();
        req_valid = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            setd(3, 32'h400 + k);
            drain_req = (k >= 2);
            @(negedge clk);
            check_eq("t4_ready", req_ready, (k < 3) ? 4'b1000 : 4'b0000);
            step();
        end
        seen = 0;
        dcyc = -1;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (drained) begin
                seen = 1;
                dcyc = cyc;
            end
            step();
        end
        check_eq("t4_drained_seen", seen, 1);
        check_eq("t4_drained_lat", dcyc - last_rsp, 1);
        check_eq("t4_acc", n_acc, 3);
        check_eq("t4_rsp", n_rsp, 3);
        @(negedge clk);
        check_eq("t4_pulse_once", drained, 0);
        check_eq("t4_idle_closed", req_ready, 0);
        check_eq("t4_busy", busy, 0);
        step();
        drain_req = 1'b0;
        req_valid = '0;
        step();

        // 5: reset with two requests in flight
        do_reset(1);
        clr_cnt();
        req_valid = 4'b0110;
        setd(1, 32'h51);
        setd(2, 32'h52);
        @(negedge clk);
        check_eq("t5_g1", req_ready, 4'b0010);
        step();
        @(negedge clk);
        check_eq("t5_g2", req_ready, 4'b0100);
        step();
        req_valid = 4'b1111;
        do_reset(1);
        for (int i = 0; i < NR; i++) setd(i, 32'h500 + i);
        @(negedge clk);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_ptr0", req_ready, 4'b0001);
        step();
        req_valid = '0;
        repeat (PS + 5) step();
        check_eq("t5_acc", n_acc, 3);
        check_eq("t5_rsp", n_rsp, 1);
        check_eq("t5_sb_empty", sbq.size(), 0);

`ifdef PIPE_ARB_STATS_EN
        // 6: counter saturation and clear
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        stat_sel = 2'd1;
        clr_cnt();
        req_valid = 4'b0010;
        for (int k = 0; k < 70000; k++) begin
            setd(1, k);
            step();
        end
        req_valid = '0;
        repeat (5) step();
        @(negedge clk);
        check_eq("t6_acc", n_acc, 70000);
        check_eq("t6_sat", stat_cnt, 16'hFFFF);
        stat_sel = 2'd0;
        step();
        @(negedge clk);
        check_eq("t6_other", stat_cnt, 0);
        stat_sel = 2'd1;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        step();
        @(negedge clk);
        check_eq("t6_clr", stat_cnt, 0);
        check_eq("t6_sb_empty", sbq.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
